// File: rtl/wired_icache_nway_pkg.sv
// Shared types for the N-way instruction cache front end: FSM states and
// the per-way tag entry returned by the tag SRAM.
package wired_icache_nway_pkg;

    typedef enum logic [2:0] {
        FREE,
        REFILL,
        UNC,
        HANDLED,
        DRAIN
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [19:0] ppn;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/wired_icache_hit.sv
// Per-way tag compare and OR-mux of the hitting way's fetch group.
module wired_icache_hit
    import wired_icache_nway_pkg::*;
#(
    parameter int WAYS    = 4,
    parameter int FETCH_W = 2
) (
    input  logic [19:0]                 ppn_i,
    input  logic [WAYS*TAG_W-1:0]       tag_i,
    input  logic [WAYS*FETCH_W*32-1:0]  data_i,
    output logic [WAYS-1:0]             hit_o,
    output logic [FETCH_W*32-1:0]       inst_o
);

    localparam int GRP_W = FETCH_W * 32;

    tag_t [WAYS-1:0] tags;

    assign tags = tag_i;

    // Tags are unique per set, so OR-ing the hit ways yields the single hit way's data.
    always_comb begin
        hit_o  = '0;
        inst_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_o[w] = tags[w].valid && (tags[w].ppn == ppn_i);
            if (hit_o[w]) begin
                inst_o = inst_o | data_i[w*GRP_W +: GRP_W];
            end
        end
    end

endmodule

// File: rtl/wired_icache_nway.sv
// Two-stage N-way instruction cache front end: S1 waits for SRAM read data,
// S2 resolves hit/miss and runs the refill / uncached bus FSM.
module wired_icache_nway
    import wired_icache_nway_pkg::*;
#(
    parameter int WAYS    = 4,
    parameter int FETCH_W = 2,
    parameter int PKG_W   = 32,
    parameter int LINE_B  = 16,
    parameter int IDX_W   = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,

    input  logic                        f_valid_i,
    output logic                        f_ready_o,
    input  logic [31:0]                 f_paddr_i,
    input  logic [FETCH_W-1:0]          f_mask_i,
    input  logic                        f_uncache_i,
    input  logic [PKG_W-1:0]            f_pkg_i,

    output logic                        f_valid_o,
    input  logic                        f_ready_i,
    output logic [31:0]                 f_paddr_o,
    output logic [FETCH_W-1:0]          f_mask_o,
    output logic [PKG_W-1:0]            f_pkg_o,
    output logic [FETCH_W*32-1:0]       f_inst_o,

    output logic [IDX_W-1:0]            s_addr_o,
    input  logic [WAYS*TAG_W-1:0]       s_tag_i,
    input  logic [WAYS*FETCH_W*32-1:0]  s_data_i,

    output logic                        bus_valid_o,
    input  logic                        bus_ready_i,
    output logic [31:0]                 bus_addr_o,
    output logic                        bus_uncached_o,
    output logic [$clog2(WAYS)-1:0]     bus_way_o,
    input  logic [FETCH_W*32-1:0]       bus_rdata_i
);

    localparam int          WAY_W     = $clog2(WAYS);
    localparam int          GRP_W     = FETCH_W * 32;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_B) - 32'd1);

    typedef struct packed {
        logic [31:0]        paddr;
        logic [FETCH_W-1:0] mask;
        logic               uncache;
        logic [PKG_W-1:0]   pkg;
    } req_t;

    typedef struct packed {
        req_t               req;
        logic               hit;
        logic [GRP_W-1:0]   inst;
    } s2_t;

    state_e           state_q, state_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WAY_W-1:0] victim_q, victim_d;

    req_t             s1_q;
    s2_t              s2_q;
    logic [GRP_W-1:0] rdata_q;

    logic [WAYS-1:0]  hit_vec;
    logic [GRP_W-1:0] hit_inst;
    logic             s1_accept;
    logic             s2_advance;
    logic             s2_leave;
    logic             s2_need_bus;
    logic             rdata_load;

    wired_icache_hit #(
        .WAYS    (WAYS),
        .FETCH_W (FETCH_W)
    ) u_hit (
        .ppn_i  (s1_q.paddr[31:12]),
        .tag_i  (s_tag_i),
        .data_i (s_data_i),
        .hit_o  (hit_vec),
        .inst_o (hit_inst)
    );

    assign s2_need_bus = s2_valid_q && (|s2_q.req.mask) && (s2_q.req.uncache || !s2_q.hit);

    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        f_valid_o   = 1'b0;
        bus_valid_o = 1'b0;
        s2_leave    = 1'b0;
        rdata_load  = 1'b0;
        case (state_q)
            FREE: begin
                f_valid_o = s2_valid_q && !s2_need_bus && !flush_i;
                s2_leave  = f_valid_o && f_ready_i;
                if (!flush_i && s2_need_bus) begin
                    state_d = s2_q.req.uncache ? UNC : REFILL;
                end
            end
            REFILL, UNC: begin
                bus_valid_o = 1'b1;
                if (bus_ready_i) begin
                    rdata_load = 1'b1;
                    state_d    = flush_i ? FREE : HANDLED;
                    if (state_q == REFILL) begin
                        victim_d = victim_q + WAY_W'(1);
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            HANDLED: begin
                f_valid_o = !flush_i;
                s2_leave  = f_valid_o && f_ready_i;
                if (flush_i || f_ready_i) begin
                    state_d = FREE;
                end
            end
            DRAIN: begin
                // The abandoned transaction still owns the bus until its response arrives.
                bus_valid_o = 1'b1;
                if (bus_ready_i) begin
                    state_d = FREE;
                    if (!s2_q.req.uncache) begin
                        victim_d = victim_q + WAY_W'(1);
                    end
                end
            end
            default: state_d = FREE;
        endcase
    end

    assign s2_advance = (state_q != DRAIN) && (!s2_valid_q || s2_leave);
    assign f_ready_o  = !s1_valid_q || s2_advance;
    assign s1_accept  = f_valid_i && f_ready_o && !flush_i;
    assign s_addr_o   = f_ready_o ? f_paddr_i[IDX_W-1:0] : s1_q.paddr[IDX_W-1:0];

    assign s1_valid_d = flush_i ? 1'b0 : (f_ready_o ? f_valid_i : s1_valid_q);
    assign s2_valid_d = flush_i ? 1'b0 : (s2_advance ? s1_valid_q : s2_valid_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FREE;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            victim_q   <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            victim_q   <= victim_d;
        end
    end

    // S1 -> S2 boundary: SRAM data for the S1 address is valid now, capture the hit result.
    always_ff @(posedge clk) begin
        if (s1_accept) begin
            s1_q <= {f_paddr_i, f_mask_i, f_uncache_i, f_pkg_i};
        end
        if (s2_advance && s1_valid_q) begin
            s2_q <= {s1_q, |hit_vec, hit_inst};
        end
        if (rdata_load) begin
            rdata_q <= bus_rdata_i;
        end
    end

    assign f_paddr_o      = s2_q.req.paddr;
    assign f_mask_o       = s2_q.req.mask;
    assign f_pkg_o        = s2_q.req.pkg;
    assign f_inst_o       = (state_q == HANDLED) ? rdata_q : s2_q.inst;

    assign bus_addr_o     = s2_q.req.uncache ? s2_q.req.paddr : (s2_q.req.paddr & LINE_MASK);
    assign bus_uncached_o = s2_q.req.uncache;
    assign bus_way_o      = victim_q;

endmodule

// File: tb/tb_wired_icache_nway.sv
// Bench for wired_icache_nway: SRAM and bus models plus an in-order queue
// reference model of expected responses and bus requests.
module tb_wired_icache_nway;

    localparam int WAYS    = 4;
    localparam int FETCH_W = 2;
    localparam int PKG_W   = 32;
    localparam int LINE_B  = 16;
    localparam int IDX_W   = 12;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush_i;
    logic                   f_valid_i, f_ready_o;
    logic [31:0]            f_paddr_i;
    logic [1:0]             f_mask_i;
    logic                   f_uncache_i;
    logic [31:0]            f_pkg_i;
    logic                   f_valid_o, f_ready_i;
    logic [31:0]            f_paddr_o;
    logic [1:0]             f_mask_o;
    logic [31:0]            f_pkg_o;
    logic [63:0]            f_inst_o;
    logic [11:0]            s_addr_o;
    logic [WAYS*21-1:0]     s_tag_i;
    logic [WAYS*64-1:0]     s_data_i;
    logic                   bus_valid_o, bus_ready_i;
    logic [31:0]            bus_addr_o;
    logic                   bus_uncached_o;
    logic [1:0]             bus_way_o;
    logic [63:0]            bus_rdata_i;

    always #5 clk = ~clk;

    wired_icache_nway #(
        .WAYS(WAYS), .FETCH_W(FETCH_W), .PKG_W(PKG_W), .LINE_B(LINE_B), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .f_valid_i(f_valid_i), .f_ready_o(f_ready_o), .f_paddr_i(f_paddr_i),
        .f_mask_i(f_mask_i), .f_uncache_i(f_uncache_i), .f_pkg_i(f_pkg_i),
        .f_valid_o(f_valid_o), .f_ready_i(f_ready_i), .f_paddr_o(f_paddr_o),
        .f_mask_o(f_mask_o), .f_pkg_o(f_pkg_o), .f_inst_o(f_inst_o),
        .s_addr_o(s_addr_o), .s_tag_i(s_tag_i), .s_data_i(s_data_i),
        .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_addr_o(bus_addr_o),
        .bus_uncached_o(bus_uncached_o), .bus_way_o(bus_way_o), .bus_rdata_i(bus_rdata_i)
    );

    // SRAM model: tag/data arrays indexed by line, read data one cycle after address.
    logic        tv [WAYS][256];
    logic [19:0] tp [WAYS][256];
    logic [11:0] sram_a_q;

    always @(posedge clk) sram_a_q <= s_addr_o;

    function automatic logic [63:0] grp(input int w, input logic [11:0] a);
        logic [31:0] s0;
        s0 = 32'hA000_0000 | (32'(w) << 24) | 32'(a);
        return {s0 | 32'h0010_0000, s0};
    endfunction

    always_comb begin
        s_tag_i  = '0;
        s_data_i = '0;
        for (int w = 0; w < WAYS; w++) begin
            s_tag_i[w*21 +: 21]  = {tv[w][sram_a_q[11:4]], tp[w][sram_a_q[11:4]]};
            s_data_i[w*64 +: 64] = grp(w, sram_a_q);
        end
    end

    // Reference model state.
    typedef struct packed {
        logic [31:0] paddr;
        logic [1:0]  mask;
        logic [31:0] pkg;
        logic [1:0]  kind;   // 0 = answered from SRAM, 1 = refill, 2 = uncached
        logic [63:0] inst;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks, errors;
    int          cyc, resp_cnt, bus_cnt, fixed_dly;
    bit          bus_busy, b_dropped, cur_refill, chk_lat, last_acc;
    logic [31:0] b_addr;
    logic        b_unc;
    logic [1:0]  b_way;
    logic [1:0]  vict_m;
    logic [19:0] pool [4];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] pa, input logic [1:0] m,
                                    input logic u, input logic [31:0] pk);
        exp_t e;
        int   hw;
        e.paddr = pa; e.mask = m; e.pkg = pk; e.inst = '0; e.acc = cyc;
        hw = -1;
        for (int w = 0; w < WAYS; w++)
            if (tv[w][pa[11:4]] && tp[w][pa[11:4]] == pa[31:12]) hw = w;
        if (hw >= 0) e.inst = grp(hw, pa[11:0]);
        if (m == 2'b00)   e.kind = 2'd0;
        else if (u)       e.kind = 2'd2;
        else if (hw < 0)  e.kind = 2'd1;
        else              e.kind = 2'd0;
        return e;
    endfunction

    task automatic tick(input bit req, input logic [31:0] pa, input logic [1:0] m,
                        input bit u, input bit fl, input bit rdy);
        exp_t e;
        @(negedge clk);
        cyc++;
        bus_ready_i = 1'b0;
        if (bus_busy && !bus_valid_o) begin
            check_eq("bus_valid_held", bus_valid_o, 1);
            bus_busy = 0;
        end
        if (bus_valid_o) begin
            if (!bus_busy) begin
                bus_busy  = 1;
                b_dropped = 0;
                bus_cnt   = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 4);
                b_addr = bus_addr_o; b_unc = bus_uncached_o; b_way = bus_way_o;
                check_eq("bus_owner", q.size() > 0, 1);
                if (q.size() > 0) begin
                    cur_refill = (q[0].kind == 2'd1);
                    check_eq("bus_kind", q[0].kind != 2'd0, 1);
                    check_eq("bus_addr", bus_addr_o,
                             (q[0].kind == 2'd2) ? q[0].paddr : (q[0].paddr & 32'hFFFF_FFF0));
                    check_eq("bus_uncached", bus_uncached_o, q[0].kind == 2'd2);
                    if (cur_refill) check_eq("bus_way", bus_way_o, vict_m);
                end else begin
                    cur_refill = !bus_uncached_o;
                end
            end else begin
                check_eq("bus_stable", {bus_addr_o, 29'b0, bus_uncached_o, bus_way_o},
                         {b_addr, 29'b0, b_unc, b_way});
            end
            if (bus_cnt == 0) begin
                bus_ready_i = 1'b1;
                bus_rdata_i = {$urandom, $urandom};
            end else begin
                bus_cnt--;
            end
        end
        f_valid_i = req; f_paddr_i = pa; f_mask_i = m; f_uncache_i = u;
        f_pkg_i = $urandom; flush_i = fl; f_ready_i = rdy;
        #1;
        if (fl) check_eq("flush_kills_valid", f_valid_o, 0);
        if (bus_ready_i) begin
            bus_busy = 0;
            if (cur_refill) vict_m = vict_m + 2'd1;
            if (!b_dropped && q.size() > 0) q[0].inst = bus_rdata_i;
        end
        if (f_valid_o) begin
            check_eq("resp_owner", q.size() > 0, 1);
            if (f_ready_i && q.size() > 0) begin
                e = q.pop_front();
                check_eq("resp_paddr", f_paddr_o, e.paddr);
                check_eq("resp_mask", f_mask_o, e.mask);
                check_eq("resp_pkg", f_pkg_o, e.pkg);
                check_eq("resp_inst", f_inst_o, e.inst);
                if (chk_lat) check_eq("resp_latency", cyc - e.acc, 2);
                resp_cnt++;
            end
        end
        last_acc = req && f_ready_o && !fl;
        if (last_acc) q.push_back(mk_exp(pa, m, u, f_pkg_i));
        if (fl) begin
            q.delete();
            if (bus_busy) b_dropped = 1;
        end
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        while ((q.size() != 0 || bus_busy || bus_valid_o) && n < 300) begin
            tick(0, 32'h0, 2'b00, 0, 0, 1);
            n++;
        end
        check_eq("drain_done", (q.size() == 0) && !bus_busy, 1);
    endtask

    task automatic wait_bus();
        int n;
        n = 0;
        while (!bus_busy && n < 20) begin
            tick(0, 32'h0, 2'b00, 0, 0, 1);
            n++;
        end
        check_eq("bus_started", bus_busy, 1);
    endtask

    task automatic clear_tags();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < 256; s++) begin
                tv[w][s] = 1'b0;
                tp[w][s] = 20'h0;
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, n, k;
        logic [31:0] pa;
        pool[0] = 20'h12345; pool[1] = 20'h00ABC; pool[2] = 20'h1C000; pool[3] = 20'h7FFFF;
        checks = 0; errors = 0; cyc = 0; resp_cnt = 0; vict_m = 2'd0;
        bus_busy = 0; b_dropped = 0; cur_refill = 0; chk_lat = 0; fixed_dly = 5;
        clear_tags();
        rst_n = 1'b0; flush_i = 0; f_valid_i = 0; f_paddr_i = 0; f_mask_i = 0;
        f_uncache_i = 0; f_pkg_i = 0; f_ready_i = 0; bus_ready_i = 0; bus_rdata_i = 0;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_f_valid", f_valid_o, 0);
        check_eq("rst_bus_valid", bus_valid_o, 0);
        check_eq("rst_f_ready", f_ready_o, 1);
        rst_n = 1'b1;

        // Hit stream, back to back
        tv[2][0] = 1'b1; tp[2][0] = 20'h12345;
        chk_lat = 1;
        base = resp_cnt;
        for (int i = 0; i < 8; i++) tick(1, 32'h1234_5008, 2'b11, 0, 0, 1);
        repeat (2) tick(0, 32'h0, 2'b00, 0, 0, 1);
        check_eq("hit_throughput", resp_cnt - base, 8);
        drain_all();
        chk_lat = 0;

        // Two misses: victim pointer advances
        tv[2][0] = 1'b0;
        tick(1, 32'h1234_5008, 2'b11, 0, 0, 1);
        drain_all();
        tick(1, 32'h1234_5010, 2'b01, 0, 0, 1);
        drain_all();

        // Uncached fetch forwarded
        tick(1, 32'h1C00_0004, 2'b01, 1, 0, 1);
        drain_all();

        // Backpressure on a hit stream
        tv[2][0] = 1'b1; tp[2][0] = 20'h12345;
        tv[0][1] = 1'b1; tp[0][1] = 20'h12345;
        base = resp_cnt; n = 0; k = 0;
        while (k < 10 && n < 100) begin
            tick(1, (k % 2 != 0) ? 32'h1234_5010 : 32'h1234_5008, 2'b11, 0, 0, !(n >= 3 && n < 7));
            if (last_acc) k++;
            n++;
        end
        drain_all();
        check_eq("bp_count", resp_cnt - base, 10);

        // Flush during refill, then a hit during drain, then another miss
        tick(1, 32'h1234_5020, 2'b11, 0, 0, 1);
        wait_bus();
        tick(0, 32'h0, 2'b00, 0, 1, 1);
        tick(1, 32'h1234_5008, 2'b11, 0, 0, 1);
        drain_all();
        tick(1, 32'h1234_5030, 2'b10, 0, 0, 1);
        drain_all();

        // mask == 0 on a miss: plain response at latency 2, no bus traffic
        chk_lat = 1;
        base = resp_cnt;
        tick(1, 32'h1234_5040, 2'b00, 0, 0, 1);
        tick(1, 32'h1C00_0048, 2'b00, 1, 0, 1);
        repeat (2) tick(0, 32'h0, 2'b00, 0, 0, 1);
        check_eq("mask0_resp", resp_cnt - base, 2);
        drain_all();
        chk_lat = 0;

        // Reset in the middle of a refill abandons it and clears the victim pointer
        tick(1, 32'h1234_5050, 2'b11, 0, 0, 1);
        wait_bus();
        @(negedge clk);
        rst_n = 1'b0; bus_ready_i = 1'b0; f_valid_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_mid_bus_valid", bus_valid_o, 0);
        check_eq("rst_mid_f_valid", f_valid_o, 0);
        q.delete(); bus_busy = 0; vict_m = 2'd0;
        rst_n = 1'b1;
        tick(1, 32'h1234_5060, 2'b11, 0, 0, 1);
        drain_all();

        // Randomized traffic
        fixed_dly = -1;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < WAYS; w++) begin
                tv[w][s] = 1'($urandom_range(0, 1));
                tp[w][s] = pool[(w + s) % 4];
            end
        for (int i = 0; i < 1500; i++) begin
            pa = {pool[$urandom_range(0, 3)], 6'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'b0};
            tick($urandom_range(0, 3) != 0, pa, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);
        end
        drain_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
